main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_main_control_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit: a Moore FSM sequencing fetch, decode,
// memory, R-type, branch, addi and jump instructions.
module main_control_fsm #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_WIDTH-1:0]    opcode,
  output logic                   pc_write,
  output logic                   branch,
  output logic                   ior_d,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic                   illegal_op,
  output logic [STATE_WIDTH-1:0] state_o
);

  typedef enum logic [STATE_WIDTH-1:0] {
    StIdle    = 0,
    StFetch   = 1,
    StDecode  = 2,
    StMemAdr  = 3,
    StMemRd   = 4,
    StMemWb   = 5,
    StMemWr   = 6,
    StRtypeEx = 7,
    StRtypeWb = 8,
    StBeq     = 9,
    StAddiEx  = 10,
    StAddiWb  = 11,
    StJump    = 12
  } state_e;

  localparam logic [OP_WIDTH-1:0] OpLw    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OpSw    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OpRtype = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OpBeq   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OpAddi  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OpJ     = OP_WIDTH'(6'b000010);

  // Plain vector (not the enum type) so stray encodings 13-15 stay representable.
  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic                   illegal_q, illegal_d;

  // State and illegal-opcode pulse registers; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d   = StFetch;
    illegal_d = 1'b0;
    case (state_q)
      StIdle:    state_d = StFetch;
      StFetch:   state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeq;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        if (opcode == OpLw) begin
          state_d = StMemRd;
        end else if (opcode == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  // Moore outputs decoded from the current state only.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ior_d      = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    case (state_q)
      StFetch: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      StDecode:  alu_src_b = 2'b11;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd:   ior_d = 1'b1;
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
      end
      StRtypeEx: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRtypeWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBeq: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_source = 2'b01;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb:  reg_write = 1'b1;
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: stimulus pushes the expected state,
// outputs and illegal_op for each cycle; a negedge monitor pops and compares.
module tb_main_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       pc_write, branch, ior_d, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] outs;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  main_control_fsm #(.OP_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .pc_write   (pc_write),
    .branch     (branch),
    .ior_d      (ior_d),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written output table, packed as
  // {pc_write, branch, ior_d, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}.
  function automatic logic [14:0] exp_outs(input logic [3:0] s);
    case (s)
      4'd1:    return 15'b1_0_0_0_1_0_0_0_0_01_00_00;
      4'd2:    return 15'b0_0_0_0_0_0_0_0_0_11_00_00;
      4'd3:    return 15'b0_0_0_0_0_0_0_0_1_10_00_00;
      4'd4:    return 15'b0_0_1_0_0_0_0_0_0_00_00_00;
      4'd5:    return 15'b0_0_0_0_0_0_1_1_0_00_00_00;
      4'd6:    return 15'b0_0_1_1_0_0_0_0_0_00_00_00;
      4'd7:    return 15'b0_0_0_0_0_0_0_0_1_00_10_00;
      4'd8:    return 15'b0_0_0_0_0_1_0_1_0_00_00_00;
      4'd9:    return 15'b0_1_0_0_0_0_0_0_1_00_01_01;
      4'd10:   return 15'b0_0_0_0_0_0_0_0_1_10_00_00;
      4'd11:   return 15'b0_0_0_0_0_0_0_1_0_00_00_00;
      4'd12:   return 15'b1_0_0_0_0_0_0_0_0_00_00_10;
      default: return 15'b0;
    endcase
  endfunction

  // Called just after a rising edge: push what this cycle must show, apply
  // the opcode steering the next transition, then advance one cycle.
  task automatic cyc(input logic [5:0] op, input logic [3:0] st, input logic ill);
    exp_t e;
    e.st   = st;
    e.outs = exp_outs(st);
    e.ill  = ill;
    exp_q.push_back(e);
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare against the oldest expectation each falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pc_write, branch, ior_d, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
      checks++;
      if (state_o !== e.st || act !== e.outs || illegal_op !== e.ill) begin
        errors++;
        $display("FAIL cycle_check t=%0t: state=%0d outs=%b ill=%b, required state=%0d outs=%b ill=%b",
                 $time, state_o, act, illegal_op, e.st, e.outs, e.ill);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    @(posedge clk);
    #1;
    // Held in reset: IDLE, all outputs 0 even across an edge.
    cyc(6'b100011, 4'd0, 1'b0);
    cyc(6'b100011, 4'd0, 1'b0);
    rst_n = 1'b1;
    // lw: 0,1,2,3,4,5 then FETCH; opcode noise in MEMRD/MEMWB is ignored.
    cyc(6'b111111, 4'd0, 1'b0);
    cyc(6'b111111, 4'd1, 1'b0);
    cyc(6'b100011, 4'd2, 1'b0);
    cyc(6'b100011, 4'd3, 1'b0);
    cyc(6'b101011, 4'd4, 1'b0);
    cyc(6'b000000, 4'd5, 1'b0);
    // sw: 1,2,3,6
    cyc(6'b000100, 4'd1, 1'b0);
    cyc(6'b101011, 4'd2, 1'b0);
    cyc(6'b101011, 4'd3, 1'b0);
    cyc(6'b100011, 4'd6, 1'b0);
    // R-type: 1,2,7,8
    cyc(6'b111111, 4'd1, 1'b0);
    cyc(6'b000000, 4'd2, 1'b0);
    cyc(6'b000100, 4'd7, 1'b0);
    cyc(6'b000010, 4'd8, 1'b0);
    // beq: 1,2,9
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b000100, 4'd2, 1'b0);
    cyc(6'b000100, 4'd9, 1'b0);
    // j: 1,2,12
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b000010, 4'd2, 1'b0);
    cyc(6'b000010, 4'd12, 1'b0);
    // Illegal opcode: DECODE -> FETCH with a one-cycle illegal_op pulse.
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b111111, 4'd2, 1'b0);
    cyc(6'b111111, 4'd1, 1'b1);
    cyc(6'b000000, 4'd2, 1'b0);
    // R-type issued from that DECODE, then lw whose opcode changes in MEMADR.
    cyc(6'b000000, 4'd7, 1'b0);
    cyc(6'b000000, 4'd8, 1'b0);
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b100011, 4'd2, 1'b0);
    cyc(6'b001000, 4'd3, 1'b0);
    // addi: 1,2,10,11
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b001000, 4'd2, 1'b0);
    cyc(6'b000000, 4'd10, 1'b0);
    cyc(6'b000000, 4'd11, 1'b0);
    // R-type again, aborted by an asynchronous reset mid RTYPE_WB.
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b000000, 4'd2, 1'b0);
    cyc(6'b000000, 4'd7, 1'b0);
    begin
      exp_t e;
      e.st   = 4'd0;
      e.outs = 15'b0;
      e.ill  = 1'b0;
      #1;
      rst_n = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    cyc(6'b000000, 4'd0, 1'b0);
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b001000, 4'd2, 1'b0);
    cyc(6'b000000, 4'd10, 1'b0);
    // From ADDI_WB, force the unreachable encoding 14: outputs 0, then FETCH.
    begin
      exp_t e;
      e.st   = 4'd14;
      e.outs = 15'b0;
      e.ill  = 1'b0;
      force dut.state_q = 4'd14;
      exp_q.push_back(e);
      @(negedge clk);
      #2;
      release dut.state_q;
      @(posedge clk);
      #1;
    end
    cyc(6'b000000, 4'd1, 1'b0);
    cyc(6'b000000, 4'd2, 1'b0);
    cyc(6'b000000, 4'd7, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
